mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles mem_req waits for mem_ack before abort.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 valid  in  1  instruction presented this cycle; accepted only while stall=0.
REQ-005 is_load / is_store  in  1 each  memory op class; both 0 = non-memory op (ALU writeback).
REQ-006 funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
REQ-007 rd  in  5  destination register; write_en  in  1  op writes rd.
REQ-008 data_alu  in  32  ALU result: effective address for memory ops, result otherwise.
REQ-009 store_data  in  32  rs2 value for stores.
REQ-010 mem_req  out  1;  mem_we  out  1;  mem_addr  out  32 (bits[1:0]=0);  mem_be  out  4;  mem_wdata  out  32.
REQ-011 mem_rdata  in  32;  mem_ack  in  1  one-cycle completion strobe.
REQ-012 stall  out  1  upstream holds its outputs while 1.
REQ-013 rf_we  out  1;  rf_addr  out  5;  rf_wdata  out  32  register-file write port, one-cycle pulse.
REQ-014 misalign  out  1;  bus_err  out  1  one-cycle fault pulses.

Function
REQ-015 States SHALL be IDLE, ACCESS, WB.
REQ-016 IDLE, valid, non-memory op: next cycle rf_we=write_en&(rd!=0), rf_addr=rd, rf_wdata=data_alu; stays IDLE; stall=0.
REQ-017 IDLE, valid, memory op, aligned: latch op/addr/data/rd, go ACCESS; stall=1 from the following cycle until completion.
REQ-018 Alignment: H/HU need addr[0]=0; W needs addr[1:0]=0; violation gives misalign=1 next cycle, no memory access, rf_we=0, stays IDLE.
REQ-019 ACCESS: mem_req=1, mem_addr={addr[31:2],2'b00}, mem_we=is_store; held stable until mem_ack.
REQ-020 Store lanes: B mem_be=0001<<addr[1:0], H 0011<<addr[1:0], W 1111; mem_wdata=store_data replicated into the selected lanes.
REQ-021 Load mem_be SHALL equal the lane mask of REQ-020; mem_wdata=0.
REQ-022 mem_ack in ACCESS: mem_req drops next cycle; store goes IDLE (stall=0 next cycle); load captures mem_rdata and goes WB.
REQ-023 WB (one cycle): rf_we=(rd!=0), rf_addr=rd, rf_wdata=selected lane, sign-extended (B/H) or zero-extended (BU/HU/W); next state IDLE; stall=0 in WB.
REQ-024 Load to rd=0 SHALL perform the bus access but never assert rf_we.
REQ-025 A wait counter SHALL clear on ACCESS entry and increment per cycle without ack; on reaching TIMEOUT_CYCLES: bus_err=1 one cycle, mem_req drops, rf_we=0, state IDLE.
REQ-026 mem_ack outside ACCESS SHALL be ignored.
REQ-027 mem_ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success, with no bus_err.
REQ-028 Total load latency: accept, ACCESS (≥1 cycle), WB; minimum 3 cycles from accept to rf_we.

Reset
REQ-029 rst=1 at posedge SHALL force state IDLE, counter 0, and every output 0 (mem_req, mem_we, mem_addr, mem_be, mem_wdata, stall, rf_we, rf_addr, rf_wdata, misalign, bus_err).
REQ-030 rst during ACCESS or WB SHALL abandon the op: no rf_we and no fault pulse afterwards; mem_req is 0 the cycle after rst.

Structure
REQ-031 Shared package fewcore_pkg SHALL hold the funct3 size constants, the state enum, and the default TIMEOUT_CYCLES.
REQ-032 Lane extraction and extension SHALL be a sub-module load_align (inputs rdata, addr[1:0], funct3; output 32-bit value).

Verification
REQ-033 SW data_alu=0x104, store_data=0xDEADBEEF, ack after 2 cycles -> mem_addr=0x104, mem_be=1111, mem_we=1, stall deasserts the cycle after ack.
REQ-034 LB addr=0x203, mem_rdata=0x80FF_FF7F, rd=5 -> rf_wdata=0xFFFFFF80, rf_we pulse; LBU same -> 0x00000080.
REQ-035 LH addr=0x101 -> misalign pulse, mem_req never 1, rf_we=0.
REQ-036 LW, no ack for 255 cycles -> bus_err pulse, mem_req=0, IDLE; ack arriving on cycle 255 -> success, no bus_err.
REQ-037 rst asserted while mem_req=1 -> mem_req=0 next cycle, no rf_we; a subsequent ALU op with rd=0 -> rf_we stays 0.

Source files
------------

// File: rtl/fewcore_pkg.sv
// Shared constants, state encoding and payload types for the fewcore load/store path.
package fewcore_pkg;

    localparam int unsigned XLEN               = 32;
    localparam int unsigned REG_AW             = 5;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WB     = 2'd2
    } state_e;

    typedef struct packed {
        logic            req;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [3:0]      be;
        logic [XLEN-1:0] wdata;
    } mem_bus_t;

    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   wdata;
    } rf_wr_t;

    typedef struct packed {
        logic              is_store;
        logic [2:0]        funct3;
        logic [1:0]        addr_lo;
        logic [REG_AW-1:0] rd;
    } op_ctx_t;

    // size is funct3[1:0]: 00 byte, 01 half, anything else word
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   lane_mask = 4'b0001 << addr_lo;
            2'b01:   lane_mask = 4'b0011 << addr_lo;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = addr_lo[0];
            default: is_misaligned = |addr_lo;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_lanes(input logic [1:0] size, input logic [XLEN-1:0] data);
        case (size)
            2'b00:   store_lanes = {4{data[7:0]}};
            2'b01:   store_lanes = {2{data[15:0]}};
            default: store_lanes = data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a bus read and sign- or zero-extends it.
module load_align
    import fewcore_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[{addr, 3'b000} +: 8];
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    value = {{24{w_byte[7]}}, w_byte};
            F3_H:    value = {{16{w_half[15]}}, w_half};
            F3_BU:   value = {24'd0, w_byte};
            F3_HU:   value = {16'd0, w_half};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory stage controller: issues one bus access per load/store, handles
// alignment faults, bus timeout and register-file writeback.
module mem_access_ctrl
    import fewcore_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [REG_AW-1:0] rd,
    input  logic              write_en,
    input  logic [XLEN-1:0]   data_alu,
    input  logic [XLEN-1:0]   store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [3:0]        mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_addr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              misalign,
    output logic              bus_err
);

    localparam int unsigned    CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    op_ctx_t          r_ctx;
    mem_bus_t         r_bus;
    rf_wr_t           r_rf;
    logic             r_stall;
    logic             r_misalign;
    logic             r_bus_err;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    op_ctx_t          w_ctx_nxt;
    mem_bus_t         w_bus_nxt;
    rf_wr_t           w_rf_nxt;
    logic             w_stall_nxt;
    logic             w_misalign_nxt;
    logic             w_bus_err_nxt;
    logic [XLEN-1:0]  w_load_value;

    load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (r_ctx.addr_lo),
        .funct3 (r_ctx.funct3),
        .value  (w_load_value)
    );

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_ctx_nxt      = r_ctx;
        w_bus_nxt      = r_bus;
        w_rf_nxt       = r_rf;
        w_rf_nxt.we    = 1'b0;
        w_stall_nxt    = 1'b0;
        w_misalign_nxt = 1'b0;
        w_bus_err_nxt  = 1'b0;

        case (r_state)
            ST_ACCESS: begin
                w_stall_nxt = 1'b1;
                if (mem_ack) begin
                    // Ack wins over a simultaneous timeout.
                    w_bus_nxt   = '0;
                    w_stall_nxt = 1'b0;
                    if (r_ctx.is_store) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt    = ST_WB;
                        w_rf_nxt.we    = (r_ctx.rd != '0);
                        w_rf_nxt.addr  = r_ctx.rd;
                        w_rf_nxt.wdata = w_load_value;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_bus_nxt     = '0;
                    w_stall_nxt   = 1'b0;
                    w_bus_err_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            // IDLE and WB both accept a new instruction (stall is low in either).
            default: begin
                w_state_nxt = ST_IDLE;
                w_bus_nxt   = '0;
                if (valid) begin
                    if (!(is_load || is_store)) begin
                        w_rf_nxt.we    = write_en && (rd != '0);
                        w_rf_nxt.addr  = rd;
                        w_rf_nxt.wdata = data_alu;
                    end else if (is_misaligned(funct3[1:0], data_alu[1:0])) begin
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_state_nxt        = ST_ACCESS;
                        w_cnt_nxt          = '0;
                        w_stall_nxt        = 1'b1;
                        w_ctx_nxt.is_store = is_store;
                        w_ctx_nxt.funct3   = funct3;
                        w_ctx_nxt.addr_lo  = data_alu[1:0];
                        w_ctx_nxt.rd       = rd;
                        w_bus_nxt.req      = 1'b1;
                        w_bus_nxt.we       = is_store;
                        w_bus_nxt.addr     = {data_alu[XLEN-1:2], 2'b00};
                        w_bus_nxt.be       = lane_mask(funct3[1:0], data_alu[1:0]);
                        w_bus_nxt.wdata    = is_store ? store_lanes(funct3[1:0], store_data) : '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ctx      <= '0;
            r_bus      <= '0;
            r_rf       <= '0;
            r_stall    <= 1'b0;
            r_misalign <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ctx      <= w_ctx_nxt;
            r_bus      <= w_bus_nxt;
            r_rf       <= w_rf_nxt;
            r_stall    <= w_stall_nxt;
            r_misalign <= w_misalign_nxt;
            r_bus_err  <= w_bus_err_nxt;
        end
    end

    assign mem_req   = r_bus.req;
    assign mem_we    = r_bus.we;
    assign mem_addr  = r_bus.addr;
    assign mem_be    = r_bus.be;
    assign mem_wdata = r_bus.wdata;
    assign stall     = r_stall;
    assign rf_we     = r_rf.we;
    assign rf_addr   = r_rf.addr;
    assign rf_wdata  = r_rf.wdata;
    assign misalign  = r_misalign;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, reset corner sequences,
// and random ops checked against an arithmetic reference model.
module tb_mem_access_ctrl;

    localparam int unsigned TIMEOUT = 255;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        write_en;
    logic [31:0] data_alu;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        misalign;
    logic        bus_err;

    int total;
    int bad;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .is_load    (is_load),
        .is_store   (is_store),
        .funct3     (funct3),
        .rd         (rd),
        .write_en   (write_en),
        .data_alu   (data_alu),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .stall      (stall),
        .rf_we      (rf_we),
        .rf_addr    (rf_addr),
        .rf_wdata   (rf_wdata),
        .misalign   (misalign),
        .bus_err    (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ack_delay: cycles without ack before the ack cycle; -1 means never ack
    typedef struct {
        logic        is_load;
        logic        is_store;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        write_en;
        logic [31:0] data_alu;
        logic [31:0] store_data;
        logic [31:0] rdata;
        int          ack_delay;
        logic        exp_misalign;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_rf_we;
        logic [31:0] exp_rf_wdata;
    } op_t;

    op_t tbl[17];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input int ld, input int st, input int f3, input int rdi, input int we,
                               input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdat,
                               input int dly, input int mis, input int be, input logic [31:0] wd,
                               input int rfwe, input logic [31:0] rfwd);
        op_t r;
        r.is_load      = 1'(ld);
        r.is_store     = 1'(st);
        r.funct3       = 3'(f3);
        r.rd           = 5'(rdi);
        r.write_en     = 1'(we);
        r.data_alu     = addr;
        r.store_data   = sd;
        r.rdata        = rdat;
        r.ack_delay    = dly;
        r.exp_misalign = 1'(mis);
        r.exp_be       = 4'(be);
        r.exp_wdata    = wd;
        r.exp_rf_we    = 1'(rfwe);
        r.exp_rf_wdata = rfwd;
        return r;
    endfunction

    // Reference model: derives expectations from access size in bytes and byte offset.
    function automatic op_t model(input op_t v);
        op_t    r;
        int     nb;
        int     a;
        longint x;
        r  = v;
        nb = 1 << int'(v.funct3[1:0]);
        a  = int'(v.data_alu[1:0]);
        r.exp_misalign = (v.is_load || v.is_store) && ((a % nb) != 0);
        r.exp_be       = 4'(((1 << nb) - 1) << a);
        r.exp_wdata    = 32'h0;
        r.exp_rf_we    = 1'b0;
        r.exp_rf_wdata = 32'h0;
        if (v.is_store) begin
            for (int i = 0; i < 4; i++) r.exp_wdata[8*i +: 8] = v.store_data[8*(i % nb) +: 8];
        end
        if (!v.is_load && !v.is_store) begin
            r.exp_rf_we    = v.write_en && (v.rd != 5'd0);
            r.exp_rf_wdata = v.data_alu;
        end else if (v.is_load && !r.exp_misalign) begin
            x = {32'd0, v.rdata};
            x = (x >> (8 * a)) & ((64'd1 << (8 * nb)) - 64'd1);
            if (!v.funct3[2] && nb < 4 && x >= (64'd1 << (8 * nb - 1))) x = x - (64'd1 << (8 * nb));
            r.exp_rf_we    = (v.rd != 5'd0);
            r.exp_rf_wdata = 32'(x);
        end
        return r;
    endfunction

    task automatic check_zero(input string nm);
        check({nm, "_ctl"}, 32'({mem_req, mem_we, stall, rf_we, misalign, bus_err}), 32'h0);
        check({nm, "_addr"}, mem_addr, 32'h0);
        check({nm, "_be_wd"}, 32'(mem_be) | mem_wdata, 32'h0);
        check({nm, "_rfaddr"}, 32'(rf_addr), 32'h0);
        check({nm, "_rfwd"}, rf_wdata, 32'h0);
    endtask

    task automatic run_op(input op_t v);
        bit held;
        int n;
        valid = 1'b1; is_load = v.is_load; is_store = v.is_store; funct3 = v.funct3;
        rd = v.rd; write_en = v.write_en; data_alu = v.data_alu; store_data = v.store_data;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        valid = 1'b0;
        if (!v.is_load && !v.is_store) begin
            check("alu_rf_we", 32'(rf_we), 32'(v.exp_rf_we));
            if (v.exp_rf_we) begin
                check("alu_rf_addr", 32'(rf_addr), 32'(v.rd));
                check("alu_rf_wdata", rf_wdata, v.exp_rf_wdata);
            end
            check("alu_quiet", 32'({mem_req, stall, misalign, bus_err}), 32'h0);
        end else if (v.exp_misalign) begin
            check("mis_pulse", 32'(misalign), 32'h1);
            check("mis_noaccess", 32'({mem_req, rf_we, stall, bus_err}), 32'h0);
        end else begin
            check("acc_ctl", 32'({mem_req, mem_we, stall}), 32'({1'b1, v.is_store, 1'b1}));
            check("acc_addr", mem_addr, v.data_alu & 32'hFFFF_FFFC);
            check("acc_be", 32'(mem_be), 32'(v.exp_be));
            check("acc_wdata", mem_wdata, v.exp_wdata);
            held = 1'b1;
            n = (v.ack_delay < 0) ? int'(TIMEOUT) - 1 : v.ack_delay;
            for (int k = 0; k < n; k++) begin
                mem_rdata = $urandom;
                @(posedge clk); #1;
                if (mem_req !== 1'b1 || stall !== 1'b1 || mem_addr !== (v.data_alu & 32'hFFFF_FFFC) ||
                    mem_be !== v.exp_be || mem_we !== v.is_store || bus_err !== 1'b0 || rf_we !== 1'b0)
                    held = 1'b0;
            end
            check("acc_hold", 32'(held), 32'h1);
            if (v.ack_delay >= 0) begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
            end
            @(posedge clk); #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            check("done_req_stall", 32'({mem_req, stall}), 32'h0);
            check("done_bus_err", 32'(bus_err), (v.ack_delay < 0) ? 32'h1 : 32'h0);
            check("done_rf_we", 32'(rf_we), 32'(v.exp_rf_we));
            if (v.exp_rf_we) begin
                check("done_rf_addr", 32'(rf_addr), 32'(v.rd));
                check("done_rf_wdata", rf_wdata, v.exp_rf_wdata);
            end
        end
    endtask

    initial begin
        op_t v;
        bit  quiet;
        int  kind;
        total = 0; bad = 0;
        rst = 1'b1; valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0; rd = 5'd0;
        write_en = 1'b0; data_alu = 32'h0; store_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        //            ld st f3 rd we addr           store_data     rdata          dly  mis be   wdata          rfwe rf_wdata
        tbl[0]  = mk(0, 1, 2, 0, 0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,         2,   0, 15, 32'hDEAD_BEEF, 0, 32'h0);
        tbl[1]  = mk(1, 0, 0, 5, 1, 32'h0000_0203, 32'h0,         32'h80FF_FF7F, 0,   0, 8,  32'h0,         1, 32'hFFFF_FF80);
        tbl[2]  = mk(1, 0, 4, 5, 1, 32'h0000_0203, 32'h0,         32'h80FF_FF7F, 1,   0, 8,  32'h0,         1, 32'h0000_0080);
        tbl[3]  = mk(1, 0, 1, 6, 1, 32'h0000_0101, 32'h0,         32'h0,         0,   1, 0,  32'h0,         0, 32'h0);
        tbl[4]  = mk(0, 0, 0, 7, 1, 32'h1234_5678, 32'h0,         32'h0,         0,   0, 0,  32'h0,         1, 32'h1234_5678);
        tbl[5]  = mk(0, 0, 0, 0, 1, 32'hAAAA_5555, 32'h0,         32'h0,         0,   0, 0,  32'h0,         0, 32'h0);
        tbl[6]  = mk(0, 0, 0, 3, 0, 32'h0BAD_F00D, 32'h0,         32'h0,         0,   0, 0,  32'h0,         0, 32'h0);
        tbl[7]  = mk(0, 1, 1, 0, 0, 32'h0000_0102, 32'h1234_ABCD, 32'h0,         1,   0, 12, 32'hABCD_ABCD, 0, 32'h0);
        tbl[8]  = mk(0, 1, 0, 0, 0, 32'h0000_0101, 32'h0000_00A5, 32'h0,         0,   0, 2,  32'hA5A5_A5A5, 0, 32'h0);
        tbl[9]  = mk(1, 0, 1, 9, 1, 32'h0000_0102, 32'h0,         32'h80FF_1234, 3,   0, 12, 32'h0,         1, 32'hFFFF_80FF);
        tbl[10] = mk(1, 0, 5, 9, 1, 32'h0000_0102, 32'h0,         32'h80FF_1234, 0,   0, 12, 32'h0,         1, 32'h0000_80FF);
        tbl[11] = mk(1, 0, 2, 0, 1, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 1,   0, 15, 32'h0,         0, 32'h0);
        tbl[12] = mk(0, 1, 2, 0, 0, 32'h0000_0106, 32'h1111_2222, 32'h0,         0,   1, 0,  32'h0,         0, 32'h0);
        tbl[13] = mk(1, 0, 2, 4, 1, 32'h0000_0200, 32'h0,         32'h0,         -1,  0, 15, 32'h0,         0, 32'h0);
        tbl[14] = mk(1, 0, 2, 4, 1, 32'h0000_0200, 32'h0,         32'h0102_0304, 254, 0, 15, 32'h0,         1, 32'h0102_0304);
        tbl[15] = mk(1, 0, 0, 31, 1, 32'h0000_0200, 32'h0,        32'h0000_007F, 0,   0, 1,  32'h0,         1, 32'h0000_007F);
        tbl[16] = mk(1, 0, 2, 8, 1, 32'h0000_0003, 32'h0,         32'h0,         0,   1, 0,  32'h0,         0, 32'h0);
        for (int i = 0; i < 17; i++) begin
            run_op(tbl[i]);
            @(posedge clk); #1;
            check("post_quiet", 32'({mem_req, stall, rf_we, misalign, bus_err}), 32'h0);
        end

        // Reset while a load is on the bus, then a late ack must be ignored.
        valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; rd = 5'd6; data_alu = 32'h300;
        @(posedge clk); #1;
        valid = 1'b0;
        check("rst_acc_req", 32'(mem_req), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("rst_acc");
        mem_ack = 1'b1; mem_rdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        quiet = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if ({mem_req, stall, rf_we, misalign, bus_err} !== 5'b0) quiet = 1'b0;
            @(posedge clk); #1;
        end
        check("rst_acc_after", 32'(quiet), 32'h1);
        run_op(mk(0, 0, 0, 0, 1, 32'h7777_7777, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0));

        // Reset during the writeback cycle of a load.
        valid = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; rd = 5'd10; data_alu = 32'h400;
        @(posedge clk); #1;
        valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("rst_wb_rf_we", 32'(rf_we), 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("rst_wb");

        // Random ops against the reference model, with stray acks in idle gaps.
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) begin
                mem_ack = ($urandom_range(0, 3) == 0); mem_rdata = $urandom;
                @(posedge clk); #1;
                mem_ack = 1'b0;
                check("idle_quiet", 32'({mem_req, stall, rf_we, misalign, bus_err}), 32'h0);
            end
            kind = int'($urandom_range(0, 2));
            v = mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
            v.is_load    = (kind == 1);
            v.is_store   = (kind == 2);
            v.rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            v.write_en   = 1'($urandom_range(0, 1));
            v.data_alu   = $urandom;
            v.store_data = $urandom;
            v.rdata      = $urandom;
            v.ack_delay  = int'($urandom_range(0, 4));
            case ($urandom_range(0, 4))
                0: v.funct3 = 3'b000;
                1: v.funct3 = 3'b001;
                2: v.funct3 = 3'b010;
                3: v.funct3 = v.is_store ? 3'b000 : 3'b100;
                default: v.funct3 = v.is_store ? 3'b001 : 3'b101;
            endcase
            v = model(v);
            run_op(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
